// File: rtl/cacheline_arbiter.sv
// Cacheline arbiter: shares one 256-bit line memory port between I-cache and D-cache.
// Latency: memory strobes rise one cycle after the request is sampled; resp is combinational with mem_resp.
// Backpressure: requests are level-held until resp; one DONE cycle follows each transaction, no grant in it.
// Build option: define ARB_DCACHE_PRIORITY_EN for fixed D-cache priority (default is round-robin).
module cacheline_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_e       state_q;
  logic         owner_q;
  logic [31:0]  mem_addr_q;
  logic         mem_read_q;
  logic         mem_write_q;
  logic [255:0] mem_wdata_q;

  logic         i_req;
  logic         d_req;
  logic         owner_d;
  logic [31:0]  mem_addr_d;
  logic         mem_read_d;
  logic         mem_write_d;
  logic [255:0] mem_wdata_d;
  logic         resp_hit;

`ifndef ARB_DCACHE_PRIORITY_EN
  logic         last_q;
`endif

  // Line offset bits of the request addresses never reach the memory port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0]};

  // Arbitration and the request snapshot that IDLE would latch this cycle.
  always_comb begin
    i_req = i_read;
    d_req = d_read | d_write;
`ifdef ARB_DCACHE_PRIORITY_EN
    owner_d = d_req ? OWNER_D : OWNER_I;
`else
    // On contention, grant whichever port was not granted last.
    if (i_req && d_req) owner_d = ~last_q;
    else                owner_d = d_req ? OWNER_D : OWNER_I;
`endif
    if (owner_d == OWNER_D) begin
      mem_addr_d  = {d_addr[31:5], 5'b0};
      // A simultaneous read and write is treated as a writeback.
      mem_write_d = d_write;
      mem_read_d  = ~d_write;
      mem_wdata_d = d_write ? d_wdata : '0;
    end else begin
      mem_addr_d  = {i_addr[31:5], 5'b0};
      mem_write_d = 1'b0;
      mem_read_d  = 1'b1;
      mem_wdata_d = '0;
    end
  end

  // Transaction FSM with registered memory-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_I;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
`ifndef ARB_DCACHE_PRIORITY_EN
      last_q      <= OWNER_D;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req || d_req) begin
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Hold everything stable until memory completes.
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
`ifndef ARB_DCACHE_PRIORITY_EN
          last_q  <= owner_q;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Completion is steered to the owner in the same cycle as mem_resp.
  always_comb begin
    resp_hit = (state_q == ST_BUSY) && mem_resp;
    i_resp   = resp_hit && (owner_q == OWNER_I);
    d_resp   = resp_hit && (owner_q == OWNER_D);
    i_rdata  = i_resp ? mem_rdata : '0;
    d_rdata  = d_resp ? mem_rdata : '0;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;

endmodule
